// File: rtl/muldiv_seq.sv
// Sequential HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with sign fix-up in a final cycle.
module muldiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_reg;
    logic        div_reg;
    logic        sa_reg;
    logic        sb_reg;
    logic        dz_reg;
    logic [31:0] ma_reg;
    logic [31:0] mb_reg;
    logic [31:0] a_raw_reg;
    logic [63:0] acc_reg;
    logic [4:0]  iter_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy_reg;
    logic        done_reg;

    logic        can_start;
    logic        accept;
    logic        sa_in;
    logic        sb_in;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        dz_in;

    assign can_start = (state_reg == IDLE) || (state_reg == DONE);
    assign accept    = start && !flush && can_start;

    // Magnitudes only for the signed ops; op[0] selects signedness.
    assign sa_in = op[0] && a[31];
    assign sb_in = op[0] && b[31];
    assign a_mag = sa_in ? (~a + 32'd1) : a;
    assign b_mag = sb_in ? (~b + 32'd1) : b;
    assign dz_in = op[1] && (b == 32'd0);

    // Multiply step: add multiplicand into the high half, shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_acc_next;
    assign mul_sum      = {1'b0, acc_reg[63:32]} + {1'b0, (mb_reg[0] ? ma_reg : 32'd0)};
    assign mul_acc_next = {mul_sum, acc_reg[31:1]};

    // Divide step: remainder in the high half, quotient shifts into the low half.
    logic [32:0] div_rem;
    logic [33:0] div_diff;
    logic        div_ok;
    logic [63:0] div_acc_next;
    assign div_rem      = {acc_reg[63:32], ma_reg[31]};
    assign div_diff     = {1'b0, div_rem} - {2'b00, mb_reg};
    assign div_ok       = !div_diff[33];
    assign div_acc_next = div_ok ? {div_diff[31:0], acc_reg[30:0], 1'b1}
                                 : {div_rem[31:0],  acc_reg[30:0], 1'b0};

    logic [63:0] prod_fix;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_hi_next;
    logic [31:0] fix_lo_next;

    assign prod_fix = (sa_reg ^ sb_reg) ? (~acc_reg + 64'd1) : acc_reg;
    assign quo      = acc_reg[31:0];
    assign rem      = acc_reg[63:32];

    always_comb begin
        fix_hi_next = prod_fix[63:32];
        fix_lo_next = prod_fix[31:0];
        if (div_reg) begin
            if (dz_reg) begin
                fix_hi_next = a_raw_reg;
                fix_lo_next = 32'hFFFF_FFFF;
            end else begin
                fix_hi_next = sa_reg ? (~rem + 32'd1) : rem;
                fix_lo_next = (sa_reg ^ sb_reg) ? (~quo + 32'd1) : quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            div_reg   <= 1'b0;
            sa_reg    <= 1'b0;
            sb_reg    <= 1'b0;
            dz_reg    <= 1'b0;
            ma_reg    <= 32'd0;
            mb_reg    <= 32'd0;
            a_raw_reg <= 32'd0;
            acc_reg   <= 64'd0;
            iter_reg  <= 5'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else if (flush) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        div_reg   <= op[1];
                        sa_reg    <= sa_in;
                        sb_reg    <= sb_in;
                        dz_reg    <= dz_in;
                        ma_reg    <= a_mag;
                        mb_reg    <= b_mag;
                        a_raw_reg <= a;
                        acc_reg   <= 64'd0;
                        iter_reg  <= 5'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= dz_in ? FIX : CALC;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                CALC: begin
                    if (div_reg) begin
                        acc_reg <= div_acc_next;
                        ma_reg  <= {ma_reg[30:0], 1'b0};
                    end else begin
                        acc_reg <= mul_acc_next;
                        mb_reg  <= {1'b0, mb_reg[31:1]};
                    end
                    iter_reg <= iter_reg + 5'd1;
                    if (iter_reg == 5'd31) begin
                        state_reg <= FIX;
                    end
                end
                FIX: begin
                    hi_reg    <= fix_hi_next;
                    lo_reg    <= fix_lo_next;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign stall = rst && ((state_reg == CALC) || (state_reg == FIX) || accept);
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: latency, signed fix-up, divide-by-zero,
// flush, start-ignore, back-to-back start in DONE and mid-operation reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle (cycle T), check stall, return in cycle T+1.
    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        #1;
        chk("stall_on_start", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
    endtask

    // Returns the cycle offset from T at which done is seen (100 on timeout).
    task automatic wait_done(input int n0, output int n, output int stall_low);
        n = n0;
        stall_low = 0;
        while (done !== 1'b1 && n < 100) begin
            if (stall !== 1'b1) stall_low++;
            tick();
            n++;
        end
    endtask

    int lat;
    int sl;
    int dcnt;

    initial begin
        // Reset, with start held high to confirm stall stays low
        start = 1'b1;
        tick();
        tick();
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        start = 1'b0;
        rst = 1'b1;
        tick();
        chk("idle_stall", {31'd0, stall}, 32'd0);

        // MULTU 0xFFFFFFFF * 0xFFFFFFFF
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_busy", {31'd0, busy}, 32'd1);
        wait_done(1, lat, sl);
        $display("MULTU ffffffff*ffffffff lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("multu_latency", lat, 34);
        chk("multu_stall_held", sl, 0);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);
        chk("done_cycle_stall", {31'd0, stall}, 32'd0);
        chk("done_cycle_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("done_one_cycle", {31'd0, done}, 32'd0);

        // MULT -3 * 5
        launch(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(1, lat, sl);
        $display("MULT -3*5 lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        tick();

        // DIV -7 / 2
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(1, lat, sl);
        $display("DIV -7/2 lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("div_latency", lat, 34);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);
        tick();

        // DIV overflow case 0x80000000 / -1
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1, lat, sl);
        $display("DIV 80000000/ffffffff lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);
        tick();

        // DIVU by zero
        launch(2'b10, 32'h1234_5678, 32'd0);
        wait_done(1, lat, sl);
        $display("DIVU 12345678/0 lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("dz_latency", lat, 2);
        chk("dz_hi", hi, 32'h1234_5678);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        tick();

        // DIVU 100/7 flushed during cycle T+10
        launch(2'b10, 32'd100, 32'd7);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        $display("DIVU 100/7 flushed dones=%0d hi=%h lo=%h", dcnt, hi, lo);
        chk("flush_no_done", dcnt, 0);
        chk("flush_hi_kept", hi, 32'h1234_5678);
        chk("flush_lo_kept", lo, 32'hFFFF_FFFF);

        // MULTU 6*7 with a start re-asserted at T+5 (must be ignored)
        launch(2'b00, 32'd6, 32'd7);
        repeat (4) tick();
        op = 2'b10;
        a = 32'd1;
        b = 32'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(6, lat, sl);
        $display("MULTU 6*7 restart-ignored lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("ignore_latency", lat, 34);
        chk("ignore_hi", hi, 32'd0);
        chk("ignore_lo", lo, 32'd42);

        // Back-to-back DIVU 9/4 started in the DONE cycle
        launch(2'b10, 32'd9, 32'd4);
        wait_done(1, lat, sl);
        $display("DIVU 9/4 from DONE lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("b2b_latency", lat, 34);
        chk("b2b_lo", lo, 32'd2);
        chk("b2b_hi", hi, 32'd1);
        tick();

        // Reset during DIV at T+15
        launch(2'b11, 32'hFFFF_FFF9, 32'd2);
        repeat (14) tick();
        rst = 1'b0;
        tick();
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        rst = 1'b1;
        tick();
        chk("midrst_idle_busy", {31'd0, busy}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) dcnt++;
            tick();
        end
        $display("DIV after mid-op reset dones=%0d", dcnt);
        chk("midrst_no_done", dcnt, 0);

        // Post-reset operations
        launch(2'b10, 32'd100, 32'd7);
        wait_done(1, lat, sl);
        $display("DIVU 100/7 lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);
        tick();

        launch(2'b11, 32'd7, 32'hFFFF_FFFE);
        wait_done(1, lat, sl);
        $display("DIV 7/-2 lat=%0d hi=%h lo=%h", lat, hi, lo);
        chk("divneg_lo", lo, 32'hFFFF_FFFD);
        chk("divneg_hi", hi, 32'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
